traffic_phase_scheduler: RTL and testbench

Demand-actuated phase scheduler for a 4-way intersection (east, south, west, north). Per-approach vehicle-request sensors are arbitrated round-robin, so only requesting approaches receive green. Green length is governed by min/max/gap-out rules, and each green is followed by fixed yellow and all-red clearance. An emergency-vehicle preemption input overrides normal arbitration. Light codes: 1=green, 2=yellow, 3=red.

---
 rtl/traffic_phase_scheduler.sv | 154 +++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated 4-way phase scheduler.
// Round-robin green selection, min/max/gap-out timing, emergency preemption.
module traffic_phase_scheduler #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int CW        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       emg_valid,
  input  logic [1:0] emg_dir,
  output logic [2:0] east,
  output logic [2:0] south,
  output logic [2:0] west,
  output logic [2:0] north,
  output logic [1:0] green_dir,
  output logic       emg_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    ALLRED = 2'd3
  } state_t;

  localparam logic [CW-1:0] GMIN1 = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX1 = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL1  = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] AR1   = CW'(ALLRED_T - 1);

  state_t        state, state_n;
  logic [1:0]    cur, cur_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [1:0]    sel;
  logic [1:0]    idx;
  logic          found;
  logic [3:0]    own_oh;
  logic          others;
  logic          own;
  logic          min_done;
  logic          max_done;
  logic          demand;
  logic          exit_green;
  logic [3:0][2:0] lamp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur   <= 2'd3;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      cnt   <= cnt_n;
    end
  end

  // Search starts after cur and wraps, so cur itself is considered last.
  always_comb begin
    sel   = cur;
    idx   = cur;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = cur + 2'(i);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    if (emg_valid) sel = emg_dir;
  end

  assign own_oh   = 4'b0001 << cur;
  assign others   = |(req & ~own_oh);
  assign own      = req[cur];
  assign min_done = cnt >= GMIN1;
  assign max_done = cnt >= GMAX1;
  assign demand   = emg_valid | (|req);

  always_comb begin
    exit_green = 1'b0;
    if (emg_valid) begin
      exit_green = emg_dir != cur;
    end else if (min_done) begin
      exit_green = (others && (!own || max_done)) || (!others && !own);
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (demand) begin
          state_n = GREEN;
          cur_n   = sel;
          cnt_n   = '0;
        end
      end
      GREEN: begin
        cnt_n = max_done ? cnt : cnt + 1'b1;
        if (exit_green) begin
          state_n = YELLOW;
          cnt_n   = '0;
        end
      end
      YELLOW: begin
        if (cnt >= YEL1) begin
          state_n = ALLRED;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ALLRED: begin
        if (cnt >= AR1) begin
          cnt_n = '0;
          if (demand) begin
            state_n = GREEN;
            cur_n   = sel;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    lamp = {4{3'd3}};
    if (state == GREEN) lamp[cur] = 3'd1;
    else if (state == YELLOW) lamp[cur] = 3'd2;
    emg_ack = (state == GREEN) && emg_valid && (emg_dir == cur);
  end

  assign east      = lamp[0];
  assign south     = lamp[1];
  assign west      = lamp[2];
  assign north     = lamp[3];
  assign green_dir = cur;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: vector table, directed
// rotation/preemption sequences and a random run against a timing model.
module tb_traffic_phase_scheduler;

  localparam int GMIN = 4;
  localparam int GMAX = 12;
  localparam int YT   = 3;
  localparam int AT   = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       emg_valid;
  logic [1:0] emg_dir;
  logic [2:0] east, south, west, north;
  logic [1:0] green_dir;
  logic       emg_ack;

  int passed = 0;
  int total  = 0;
  int cycle  = 0;

  traffic_phase_scheduler #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YT), .ALLRED_T(AT), .CW(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .emg_valid(emg_valid),
    .emg_dir(emg_dir), .east(east), .south(south), .west(west),
    .north(north), .green_dir(green_dir), .emg_ack(emg_ack)
  );

  always #5 clk = ~clk;

  // Model: which colour the served approach shows and how long it has.
  // m_col: 0 resting red, 1 green, 2 yellow, 3 clearance red
  int m_col  = 0;
  int m_dir  = 3;
  int m_age  = 0;
  int m_left = 0;
  logic [2:0] prev [4];

  typedef struct {
    logic        r;
    logic [3:0]  q;
    logic        ev;
    logic [1:0]  ed;
    logic [11:0] lights;
    logic [1:0]  gd;
    logic        ack;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic r, input logic [3:0] q,
                              input logic ev, input logic [1:0] ed,
                              input logic [11:0] l, input logic [1:0] gd,
                              input logic ack);
    vec_t v;
    v.r = r; v.q = q; v.ev = ev; v.ed = ed;
    v.lights = l; v.gd = gd; v.ack = ack;
    return v;
  endfunction

  function automatic int pick(input logic [3:0] q, input logic ev,
                              input logic [1:0] ed, input int from);
    if (ev) return int'(ed);
    for (int k = 1; k <= 4; k++)
      if (q[(from + k) % 4]) return (from + k) % 4;
    return from;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] q,
                            input logic ev, input logic [1:0] ed);
    int  served;
    bit  others;
    bit  own;
    if (r) begin
      m_col = 0; m_dir = 3; m_age = 0; m_left = 0;
      return;
    end
    case (m_col)
      0: begin
        if (ev || q != 4'd0) begin
          m_dir = pick(q, ev, ed, m_dir);
          m_col = 1;
          m_age = 0;
        end
      end
      1: begin
        served = m_age + 1;
        others = (q & ~(4'b0001 << m_dir)) != 4'd0;
        own    = q[m_dir];
        if ((ev && int'(ed) != m_dir) ||
            (!ev && served >= GMIN && !own) ||
            (!ev && served >= GMIN && others && served >= GMAX)) begin
          m_col  = 2;
          m_left = YT;
        end else begin
          m_age++;
        end
      end
      2: begin
        m_left--;
        if (m_left == 0) begin
          m_col  = 3;
          m_left = AT;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          if (ev || q != 4'd0) begin
            m_dir = pick(q, ev, ed, m_dir);
            m_col = 1;
            m_age = 0;
          end else begin
            m_col = 0;
          end
        end
      end
    endcase
  endtask

  function automatic logic [14:0] model_vec();
    logic [11:0] l;
    logic        ack;
    l = 12'o3333;
    if (m_col == 1) l[11 - 3 * m_dir -: 3] = 3'd1;
    if (m_col == 2) l[11 - 3 * m_dir -: 3] = 3'd2;
    ack = (m_col == 1) && emg_valid && (int'(emg_dir) == m_dir);
    return {l, 2'(m_dir), ack};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {east, south, west, north, green_dir, emg_ack};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s @cycle %0d: got %0h want %0h",
                  name, cycle, act, exp);
  endtask

  task automatic tick(input logic r, input logic [3:0] q,
                      input logic ev, input logic [1:0] ed);
    logic [2:0] now [4];
    int lit;
    bit legal;
    rst = r; req = q; emg_valid = ev; emg_dir = ed;
    @(posedge clk);
    model_step(r, q, ev, ed);
    #1;
    cycle++;
    chk("model", 32'(dut_vec()), 32'(model_vec()));
    now[0] = east; now[1] = south; now[2] = west; now[3] = north;
    lit = 0;
    legal = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (now[i] != 3'd3) lit++;
      if (now[i] != prev[i] &&
          !(prev[i] == 3'd1 && now[i] == 3'd2) &&
          !(prev[i] == 3'd2 && now[i] == 3'd3) &&
          !(prev[i] == 3'd3 && now[i] == 3'd1)) legal = 1'b0;
    end
    chk("one_lit", 32'(lit <= 1), 32'd1);
    if (!r) chk("transition", 32'(legal), 32'd1);
    for (int i = 0; i < 4; i++) prev[i] = now[i];
  endtask

  initial begin
    int onset [$];
    int odir [$];
    bit ok;
    logic [1:0] ed;
    logic       ev;

    for (int i = 0; i < 4; i++) prev[i] = 3'd3;
    rst = 1'b1; req = 4'd0; emg_valid = 1'b0; emg_dir = 2'd0;

    tbl[0]  = mk(1'b1, 4'hF, 1'b0, 2'd0, 12'o3333, 2'd3, 1'b0);
    tbl[1]  = mk(1'b1, 4'hF, 1'b0, 2'd0, 12'o3333, 2'd3, 1'b0);
    tbl[2]  = mk(1'b0, 4'hF, 1'b0, 2'd0, 12'o1333, 2'd0, 1'b0);
    tbl[3]  = mk(1'b0, 4'h1, 1'b0, 2'd0, 12'o1333, 2'd0, 1'b0);
    tbl[4]  = mk(1'b0, 4'h1, 1'b0, 2'd0, 12'o1333, 2'd0, 1'b0);
    tbl[5]  = mk(1'b0, 4'h0, 1'b0, 2'd0, 12'o1333, 2'd0, 1'b0);
    tbl[6]  = mk(1'b0, 4'h0, 1'b0, 2'd0, 12'o2333, 2'd0, 1'b0);
    tbl[7]  = mk(1'b0, 4'h0, 1'b0, 2'd0, 12'o2333, 2'd0, 1'b0);
    tbl[8]  = mk(1'b0, 4'h0, 1'b0, 2'd0, 12'o2333, 2'd0, 1'b0);
    tbl[9]  = mk(1'b0, 4'h0, 1'b0, 2'd0, 12'o3333, 2'd0, 1'b0);
    tbl[10] = mk(1'b0, 4'h0, 1'b0, 2'd0, 12'o3333, 2'd0, 1'b0);
    tbl[11] = mk(1'b0, 4'h4, 1'b0, 2'd0, 12'o3313, 2'd2, 1'b0);
    tbl[12] = mk(1'b0, 4'h4, 1'b1, 2'd2, 12'o3313, 2'd2, 1'b1);
    tbl[13] = mk(1'b0, 4'h4, 1'b1, 2'd0, 12'o3323, 2'd2, 1'b0);
    tbl[14] = mk(1'b0, 4'h4, 1'b1, 2'd0, 12'o3323, 2'd2, 1'b0);
    tbl[15] = mk(1'b0, 4'h4, 1'b1, 2'd0, 12'o3323, 2'd2, 1'b0);
    tbl[16] = mk(1'b0, 4'h4, 1'b1, 2'd0, 12'o3333, 2'd2, 1'b0);
    tbl[17] = mk(1'b0, 4'h4, 1'b1, 2'd0, 12'o1333, 2'd0, 1'b1);
    tbl[18] = mk(1'b0, 4'h0, 1'b0, 2'd0, 12'o1333, 2'd0, 1'b0);

    for (int i = 0; i < 19; i++) begin
      tick(tbl[i].r, tbl[i].q, tbl[i].ev, tbl[i].ed);
      chk($sformatf("vec%0d", i), 32'(dut_vec()),
          32'({tbl[i].lights, tbl[i].gd, tbl[i].ack}));
    end

    // Full rotation with every approach demanding.
    tick(1'b1, 4'hF, 1'b0, 2'd0);
    tick(1'b1, 4'hF, 1'b0, 2'd0);
    for (int c = 0; c < 140; c++) begin
      logic [2:0] was [4];
      for (int i = 0; i < 4; i++) was[i] = prev[i];
      tick(1'b0, 4'hF, 1'b0, 2'd0);
      if (east == 3'd1 && was[0] != 3'd1) begin onset.push_back(c); odir.push_back(0); end
      if (south == 3'd1 && was[1] != 3'd1) begin onset.push_back(c); odir.push_back(1); end
      if (west == 3'd1 && was[2] != 3'd1) begin onset.push_back(c); odir.push_back(2); end
      if (north == 3'd1 && was[3] != 3'd1) begin onset.push_back(c); odir.push_back(3); end
    end
    chk("rot_count", 32'(onset.size() >= 5), 32'd1);
    if (onset.size() >= 5) begin
      chk("rot_order", 32'({odir[0][1:0], odir[1][1:0], odir[2][1:0],
                            odir[3][1:0], odir[4][1:0]}), 32'b00_01_10_11_00);
      chk("rot_first", 32'(onset[0]), 32'd0);
      chk("rot_slot", 32'(onset[1] - onset[0]), 32'd16);
      chk("rot_period", 32'(onset[4] - onset[0]), 32'd64);
    end

    // Preemption of south by north, then release.
    tick(1'b1, 4'h0, 1'b0, 2'd0);
    tick(1'b1, 4'h0, 1'b0, 2'd0);
    tick(1'b0, 4'h2, 1'b0, 2'd0);
    chk("pre_south_green", 32'(south), 32'd1);
    tick(1'b0, 4'h3, 1'b0, 2'd0);
    tick(1'b0, 4'h3, 1'b1, 2'd3);
    chk("pre_south_yellow", 32'(south), 32'd2);
    tick(1'b0, 4'h3, 1'b1, 2'd3);
    tick(1'b0, 4'h3, 1'b1, 2'd3);
    tick(1'b0, 4'h3, 1'b1, 2'd3);
    chk("pre_allred", 32'({east, south, west, north}), 32'(12'o3333));
    ok = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick(1'b0, 4'h3, 1'b1, 2'd3);
      if (north != 3'd1 || emg_ack != 1'b1) ok = 1'b0;
    end
    chk("pre_north_hold", 32'(ok), 32'd1);
    tick(1'b0, 4'h3, 1'b0, 2'd0);
    chk("pre_release", 32'({north, emg_ack}), 32'({3'd2, 1'b0}));
    tick(1'b0, 4'h3, 1'b0, 2'd0);
    tick(1'b0, 4'h3, 1'b0, 2'd0);
    tick(1'b0, 4'h3, 1'b0, 2'd0);
    tick(1'b0, 4'h3, 1'b0, 2'd0);
    chk("pre_east_next", 32'({east, green_dir}), 32'({3'd1, 2'd0}));

    // Random demand and preemption episodes.
    ev = 1'b0;
    ed = 2'd0;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] q;
      if ($urandom_range(0, 24) == 0) ev = ~ev;
      if ($urandom_range(0, 39) == 0) ed = 2'($urandom_range(0, 3));
      q = ($urandom_range(0, 3) == 0) ? 4'($urandom) : req;
      tick(($urandom_range(0, 499) == 0), q, ev, ed);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
